exc_ctrl: RTL and testbench

Exception and interrupt sequencer for the MEM stage. It samples per-instruction exception flags and the synchronised interrupt lines, then chooses the single highest-priority event. It drives the one-cycle commit strobe and exception type into the CP0 register file, and sequences the pipeline flush and the fetch redirect (handler vector or EPC) through a small FSM. It sits between the MEM pipeline register and the CP0 register file and feeds the hazard unit and the PC-select logic.

---
 rtl/exc_pkg.sv | 42 ++++
 rtl/exc_ctrl_if.sv | 36 +++
 rtl/exc_prio.sv | 37 +++
 rtl/exc_ctrl.sv | 121 ++++++++++++
 tb/tb_exc_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// Shared constants for the MEM-stage exception sequencer: type codes,
// flag bit positions, FSM states and CP0 Status/Cause field positions.
package exc_pkg;

  localparam logic [31:0] EXC_TYPE_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_TYPE_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_TYPE_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_TYPE_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_TYPE_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_TYPE_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_TYPE_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000e;

  localparam int unsigned FLAG_ADEL_FETCH = 0;
  localparam int unsigned FLAG_RI         = 1;
  localparam int unsigned FLAG_OV         = 2;
  localparam int unsigned FLAG_SYS        = 3;
  localparam int unsigned FLAG_BP         = 4;
  localparam int unsigned FLAG_ADEL_DATA  = 5;
  localparam int unsigned FLAG_ADES       = 6;
  localparam int unsigned FLAG_ERET       = 7;

  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;
  localparam int unsigned STATUS_IM_HI = 15;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_IP_HI  = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } exc_state_t;

  typedef enum logic [1:0] {
    BAD_NONE = 2'd0,
    BAD_PC   = 2'd1,
    BAD_DATA = 2'd2
  } bad_sel_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 / PC-select signal bundle around the exception sequencer.
interface exc_ctrl_if;
  logic        validM;
  logic        stallM;
  logic [31:0] pcM;
  logic        is_in_delayslotM;
  logic [7:0]  exc_flagsM;
  logic [31:0] pc_badM;
  logic [31:0] data_badM;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        cp0_en;
  logic [31:0] except_type;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] badvaddr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output validM, stallM, pcM, is_in_delayslotM, exc_flagsM, pc_badM,
           data_badM, status_i, cause_i, epc_i, redirect_ready,
    input  cp0_en, except_type, exc_pc, exc_bd, badvaddr, flush,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  validM, stallM, pcM, is_in_delayslotM, exc_flagsM, pc_badM,
           data_badM, status_i, cause_i, epc_i, redirect_ready,
    output cp0_en, except_type, exc_pc, exc_bd, badvaddr, flush,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_prio.sv
// Fixed-priority selection of the single exception/interrupt to report.
module exc_prio
  import exc_pkg::*;
(
  input  logic        int_pend,
  input  logic [7:0]  flags,
  output logic [31:0] code,
  output logic        hit,
  output bad_sel_t    bad_sel
);

  always_comb begin
    code    = '0;
    hit     = 1'b1;
    bad_sel = BAD_NONE;
    if (int_pend)                      code = EXC_TYPE_INT;
    else if (flags[FLAG_ADEL_FETCH]) begin
      code    = EXC_TYPE_ADEL;
      bad_sel = BAD_PC;
    end
    else if (flags[FLAG_RI])           code = EXC_TYPE_RI;
    else if (flags[FLAG_OV])           code = EXC_TYPE_OV;
    else if (flags[FLAG_SYS])          code = EXC_TYPE_SYS;
    else if (flags[FLAG_BP])           code = EXC_TYPE_BP;
    else if (flags[FLAG_ADEL_DATA]) begin
      code    = EXC_TYPE_ADEL;
      bad_sel = BAD_DATA;
    end
    else if (flags[FLAG_ADES]) begin
      code    = EXC_TYPE_ADES;
      bad_sel = BAD_DATA;
    end
    else if (flags[FLAG_ERET])         code = EXC_TYPE_ERET;
    else                               hit  = 1'b0;
  end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt sequencer: picks one event, strobes CP0,
// then flushes and redirects fetch to the handler vector or EPC.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [5:0]     ext_int,
  exc_ctrl_if.slave      bus
);

  logic [5:0]  sync_q [SYNC_STAGES];
  logic [5:0]  int_sync;
  logic [7:0]  ip;
  logic        int_pend;
  logic [31:0] sel_code;
  logic        sel_hit;
  bad_sel_t    sel_bad;
  logic [31:0] bad_d;
  logic        take;

  exc_state_t  state_q, state_d;
  logic [31:0] type_q, pc_q, bad_q, rpc_q;
  logic        bd_q, eret_q;
  logic        cp0_en_c, flush_c, redir_c;
  logic        unused_bits;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign int_sync = sync_q[SYNC_STAGES-1];
  assign ip       = {int_sync, bus.cause_i[CAUSE_IP_LO +: 2]} & bus.status_i[STATUS_IM_HI:STATUS_IM_LO];
  assign int_pend = (|ip) & bus.status_i[STATUS_IE] & ~bus.status_i[STATUS_EXL];

  assign unused_bits = ^{bus.status_i[31:STATUS_IM_HI+1], bus.status_i[STATUS_IM_LO-1:STATUS_EXL+1],
                         bus.cause_i[31:CAUSE_IP_HI+1], bus.cause_i[CAUSE_IP_HI:CAUSE_IP_LO+2],
                         bus.cause_i[CAUSE_IP_LO-1:0]};

  exc_prio u_prio (
    .int_pend (int_pend),
    .flags    (bus.exc_flagsM),
    .code     (sel_code),
    .hit      (sel_hit),
    .bad_sel  (sel_bad)
  );

  always_comb begin
    unique case (sel_bad)
      BAD_PC:   bad_d = bus.pc_badM;
      BAD_DATA: bad_d = bus.data_badM;
      default:  bad_d = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    cp0_en_c = 1'b0;
    flush_c  = 1'b0;
    redir_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        take = bus.validM & ~bus.stallM & sel_hit;
        if (take) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        cp0_en_c = 1'b1;
        flush_c  = 1'b1;
        state_d  = ST_REDIR;
      end
      ST_REDIR: begin
        flush_c = 1'b1;
        redir_c = 1'b1;
        if (bus.redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      type_q  <= '0;
      pc_q    <= '0;
      bd_q    <= 1'b0;
      bad_q   <= '0;
      eret_q  <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        type_q <= sel_code;
        pc_q   <= bus.pcM;
        bd_q   <= bus.is_in_delayslotM;
        bad_q  <= bad_d;
        eret_q <= (sel_code == EXC_TYPE_ERET);
      end
      // EPC is captured on entry to REDIR so the target holds while waiting for ready
      if (state_q == ST_FLUSH) rpc_q <= eret_q ? bus.epc_i : EXC_VECTOR;
    end
  end

  assign bus.cp0_en         = cp0_en_c;
  assign bus.flush          = flush_c;
  assign bus.redirect_valid = redir_c;
  assign bus.redirect_pc    = rpc_q;
  assign bus.except_type    = type_q;
  assign bus.exc_pc         = pc_q;
  assign bus.exc_bd         = bd_q;
  assign bus.badvaddr       = bad_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized traffic
// compared each cycle against an event-age reference model.
module tb_exc_ctrl;

  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam int          SYNC = 2;

  // flag bit i in priority order (bit0 highest after interrupt)
  localparam logic [31:0] FLAG_CODE [8] = '{32'h04, 32'h0a, 32'h0c, 32'h08,
                                            32'h09, 32'h04, 32'h05, 32'h0e};
  // 0: no bad address, 1: fetch address, 2: data address
  localparam int          FLAG_BAD  [8] = '{1, 0, 0, 0, 0, 2, 2, 0};

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [5:0] ext_int = '0;

  exc_ctrl_if bus ();

  exc_ctrl #(.EXC_VECTOR(VEC), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .ext_int (ext_int),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: age of the current event (-1 none, 1 strobe cycle, >=2 redirecting)
  int          age;
  logic [31:0] m_type, m_pc, m_bad, m_target;
  logic        m_bd, m_eret;
  logic [5:0]  hist [$];

  task automatic model_reset();
    age = -1; m_type = '0; m_pc = '0; m_bad = '0; m_target = '0;
    m_bd = 1'b0; m_eret = 1'b0;
    hist.delete();
  endtask

  task automatic model_step();
    logic [5:0]  isync;
    logic [7:0]  ipv;
    logic        pend;
    if (!resetn) begin
      model_reset();
      return;
    end
    isync = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : 6'd0;
    ipv   = {isync, bus.cause_i[9:8]} & bus.status_i[15:8];
    pend  = (ipv != 0) && bus.status_i[0] && !bus.status_i[1];
    if (age < 0) begin
      if (bus.validM && !bus.stallM) begin
        int pick;
        pick = -1;
        for (int i = 7; i >= 0; i--) if (bus.exc_flagsM[i]) pick = i;
        if (pend || pick >= 0) begin
          age  = 1;
          m_pc = bus.pcM;
          m_bd = bus.is_in_delayslotM;
          if (pend) begin
            m_type = 32'h01; m_bad = '0;
          end else begin
            m_type = FLAG_CODE[pick];
            m_bad  = (FLAG_BAD[pick] == 1) ? bus.pc_badM :
                     (FLAG_BAD[pick] == 2) ? bus.data_badM : 32'h0;
          end
          m_eret = (!pend && pick == 7);
        end
      end
    end else if (age == 1) begin
      age      = 2;
      m_target = m_eret ? bus.epc_i : VEC;
    end else if (bus.redirect_ready) begin
      age = -1;
    end else begin
      age++;
    end
    hist.push_back(ext_int);
    if (hist.size() > SYNC) void'(hist.pop_front());
  endtask

  task automatic check();
    chk("cp0_en", {31'b0, bus.cp0_en}, {31'b0, age == 1});
    chk("flush", {31'b0, bus.flush}, {31'b0, age >= 1});
    chk("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, age >= 2});
    if (age == 1) begin
      chk("except_type", bus.except_type, m_type);
      chk("exc_pc", bus.exc_pc, m_pc);
      chk("exc_bd", {31'b0, bus.exc_bd}, {31'b0, m_bd});
      chk("badvaddr", bus.badvaddr, m_bad);
    end
    if (age >= 2) chk("redirect_pc", bus.redirect_pc, m_target);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check();
  endtask

  task automatic quiet_inputs();
    bus.validM = 1'b0; bus.stallM = 1'b0; bus.pcM = '0; bus.is_in_delayslotM = 1'b0;
    bus.exc_flagsM = '0; bus.pc_badM = '0; bus.data_badM = '0;
    bus.status_i = '0; bus.cause_i = '0; bus.epc_i = '0; bus.redirect_ready = 1'b1;
  endtask

  task automatic drain();
    quiet_inputs();
    repeat (4) cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cp0_en"}, {31'b0, bus.cp0_en}, 32'h0);
    chk({tag, "_flush"}, {31'b0, bus.flush}, 32'h0);
    chk({tag, "_redirect_valid"}, {31'b0, bus.redirect_valid}, 32'h0);
    chk({tag, "_redirect_pc"}, bus.redirect_pc, 32'h0);
    chk({tag, "_except_type"}, bus.except_type, 32'h0);
    chk({tag, "_exc_pc"}, bus.exc_pc, 32'h0);
    chk({tag, "_exc_bd"}, {31'b0, bus.exc_bd}, 32'h0);
    chk({tag, "_badvaddr"}, bus.badvaddr, 32'h0);
  endtask

  logic [31:0] status_pick [6];

  initial begin
    status_pick = '{32'h0000_0401, 32'h0000_0403, 32'h0000_FF01,
                    32'h0000_0000, 32'h0000_0301, 32'h0000_0C01};
    quiet_inputs();
    model_reset();
    resetn = 1'b0;
    repeat (2) cycle();
    chk_all_zero("reset");
    resetn = 1'b1;
    repeat (2) cycle();

    // Overflow in a delay slot
    bus.validM = 1'b1; bus.exc_flagsM = 8'h04; bus.pcM = 32'h8000_1004;
    bus.is_in_delayslotM = 1'b1;
    cycle();
    bus.validM = 1'b0; bus.exc_flagsM = '0; bus.is_in_delayslotM = 1'b0;
    chk("ov_cp0_en", {31'b0, bus.cp0_en}, 32'h1);
    chk("ov_type", bus.except_type, 32'h0000_000c);
    chk("ov_exc_pc", bus.exc_pc, 32'h8000_1004);
    chk("ov_bd", {31'b0, bus.exc_bd}, 32'h1);
    cycle();
    chk("ov_redirect_valid", {31'b0, bus.redirect_valid}, 32'h1);
    chk("ov_redirect_pc", bus.redirect_pc, 32'hBFC0_0380);
    cycle();
    chk("ov_redirect_done", {31'b0, bus.redirect_valid}, 32'h0);
    drain();

    // Several flags at once: ri wins, no bad address
    bus.validM = 1'b1; bus.exc_flagsM = 8'h92; bus.pc_badM = 32'h1111_0000;
    bus.data_badM = 32'h2222_0000;
    cycle();
    chk("multi_type", bus.except_type, 32'h0000_000a);
    chk("multi_badvaddr", bus.badvaddr, 32'h0);
    drain();

    // Interrupt on IP2 with IE=1: eligible after the synchroniser
    bus.status_i = 32'h0000_0401; bus.validM = 1'b1; ext_int = 6'h01;
    cycle();
    chk("int_early1", {31'b0, bus.cp0_en}, 32'h0);
    cycle();
    chk("int_early2", {31'b0, bus.cp0_en}, 32'h0);
    cycle();
    ext_int = '0;
    chk("int_taken", {31'b0, bus.cp0_en}, 32'h1);
    chk("int_type", bus.except_type, 32'h0000_0001);
    drain();
    repeat (3) cycle();

    // EXL=1 masks the interrupt
    bus.status_i = 32'h0000_0403; bus.validM = 1'b1; ext_int = 6'h01;
    repeat (5) begin
      cycle();
      chk("exl_no_event", {31'b0, bus.cp0_en | bus.flush}, 32'h0);
    end
    ext_int = '0;
    drain();
    repeat (3) cycle();

    // ERET with the redirect held off; EPC changes after capture
    bus.validM = 1'b1; bus.exc_flagsM = 8'h80; bus.epc_i = 32'h8000_2000;
    bus.redirect_ready = 1'b0;
    cycle();
    bus.validM = 1'b0; bus.exc_flagsM = '0;
    chk("eret_type", bus.except_type, 32'h0000_000e);
    cycle();
    bus.epc_i = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      chk("eret_hold_valid", {31'b0, bus.redirect_valid}, 32'h1);
      chk("eret_hold_pc", bus.redirect_pc, 32'h8000_2000);
      cycle();
    end
    bus.redirect_ready = 1'b1;
    cycle();
    chk("eret_released", {31'b0, bus.redirect_valid}, 32'h0);
    drain();

    // Stalled event waits for the stall to drop
    bus.validM = 1'b1; bus.exc_flagsM = 8'h04; bus.stallM = 1'b1;
    repeat (4) begin
      cycle();
      chk("stall_no_strobe", {31'b0, bus.cp0_en}, 32'h0);
    end
    bus.stallM = 1'b0;
    cycle();
    bus.validM = 1'b0; bus.exc_flagsM = '0;
    chk("stall_strobe", {31'b0, bus.cp0_en}, 32'h1);
    drain();

    // Reset pulsed while redirecting
    bus.validM = 1'b1; bus.exc_flagsM = 8'h08; bus.pcM = 32'h8000_3000;
    bus.redirect_ready = 1'b0;
    cycle();
    bus.validM = 1'b0; bus.exc_flagsM = '0;
    cycle();
    chk("rst_pre_redirect", {31'b0, bus.redirect_valid}, 32'h1);
    resetn = 1'b0;
    model_reset();
    #1;
    chk_all_zero("midreset");
    cycle();
    resetn = 1'b1;
    bus.redirect_ready = 1'b1;
    cycle();
    bus.validM = 1'b1; bus.exc_flagsM = 8'h20; bus.data_badM = 32'hDEAD_0000;
    cycle();
    bus.validM = 1'b0; bus.exc_flagsM = '0;
    chk("post_rst_strobe", {31'b0, bus.cp0_en}, 32'h1);
    chk("post_rst_type", bus.except_type, 32'h0000_0004);
    chk("post_rst_bad", bus.badvaddr, 32'hDEAD_0000);
    drain();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      resetn               = ($urandom_range(0, 499) != 0);
      if (!resetn) model_reset();
      bus.validM           = ($urandom_range(0, 3) != 0);
      bus.stallM           = ($urandom_range(0, 4) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 5)      bus.exc_flagsM = '0;
      else if (r < 8) bus.exc_flagsM = 8'(1 << $urandom_range(0, 7));
      else            bus.exc_flagsM = 8'($urandom);
      if ($urandom_range(0, 15) == 0) ext_int = 6'($urandom);
      if ($urandom_range(0, 31) == 0) bus.status_i = status_pick[$urandom_range(0, 5)];
      bus.cause_i          = $urandom;
      bus.pcM              = $urandom;
      bus.pc_badM          = $urandom;
      bus.data_badM        = $urandom;
      bus.epc_i            = $urandom;
      bus.is_in_delayslotM = 1'($urandom);
      bus.redirect_ready   = 1'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
